// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory target with LATENCY wait
//               states and RV32I byte/half/word lanes with sign/zero extension.
//               Optional misalignment checking via DMEM_MISALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic               r_write;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [2:0]         r_funct3;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_is_b;
    logic               w_is_h;
    logic               w_uns;
    logic [1:0]         w_off;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_rword;
    logic [3:0]         w_be;
    logic [31:0]        w_wlanes;
    logic [31:0]        w_ext;
    logic               w_misalign;
    logic               w_commit;

    assign w_is_b   = (r_funct3 == 3'b000) || (r_funct3 == 3'b100);
    assign w_is_h   = (r_funct3 == 3'b001) || (r_funct3 == 3'b101);
    assign w_uns    = r_funct3[2];
    assign w_idx    = c_IDX_W'(r_addr[31:2] % 30'(DEPTH_WORDS));
    assign w_rword  = r_mem[w_idx];
    assign w_commit = (r_state == c_WAIT) && (r_cnt == 4'd0) && !rst;

`ifdef DMEM_MISALIGN_CHK_EN
    assign w_misalign = (w_is_h && r_addr[0]) ||
                        (!w_is_b && !w_is_h && (r_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Halves and words snap to their naturally aligned container
    always_comb begin
        w_off    = 2'b00;
        w_be     = 4'b1111;
        w_wlanes = r_wdata;
        w_ext    = w_rword;
        if (w_is_b) begin
            w_off    = r_addr[1:0];
            w_be     = 4'b0001 << r_addr[1:0];
            w_wlanes = {4{r_wdata[7:0]}};
            w_ext    = {{24{~w_uns & w_rword[8*w_off+7]}}, w_rword[8*w_off +: 8]};
        end else if (w_is_h) begin
            w_off    = {r_addr[1], 1'b0};
            w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{r_wdata[15:0]}};
            w_ext    = {{16{~w_uns & w_rword[8*w_off+15]}}, w_rword[8*w_off +: 16]};
        end
    end

    assign req_ready = (r_state == c_IDLE) && !rst;
    assign rsp_valid = (r_state == c_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= 4'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'b010;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        r_cnt    <= 4'(LATENCY);
                        r_state  <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rdata <= (r_write || w_misalign) ? 32'd0 : w_ext;
                        r_err   <= w_misalign;
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Storage is never reset; a request dropped by reset never reaches commit
    always_ff @(posedge clk) begin
        if (w_commit && r_write && !w_misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder against a byte-array
//               reference model; directed scenarios followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int unsigned c_DEPTH   = 1024;
    localparam int unsigned c_LATENCY = 2;
    localparam int unsigned c_BYTES   = c_DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'b010;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;
    logic [7:0] model_mem [c_BYTES];

    dmem_responder #(.DEPTH_WORDS(c_DEPTH), .LATENCY(c_LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, access size from funct3, arithmetic extension
    task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, output logic [31:0] rd, output logic err);
        int nb;
        bit uns;
        longint v;
        int ba;
        int ea;
        nb  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        uns = (f3 == 3'd4 || f3 == 3'd5);
        ba  = int'(addr % c_BYTES);
        ea  = ba - (ba % nb);
        err = 1'b0;
        rd  = 32'd0;
`ifdef DMEM_MISALIGN_CHK_EN
        if ((addr % nb) != 0) err = 1'b1;
`endif
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) model_mem[ea+i] = 8'((wdata >> (8*i)) & 32'hFF);
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v + (longint'(model_mem[ea+i]) << (8*i));
                if (!uns && nb < 4 && v >= (longint'(1) << (8*nb-1))) v = v - (longint'(1) << (8*nb));
                rd = 32'(v);
            end
        end
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input int hold, input string tag);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        model_access(wr, addr, wdata, f3, exp_rd, exp_err);
        @(negedge clk);
        req_write = wr; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, ".latency"}, 32'(n), 32'(c_LATENCY + 1));
        check({tag, ".rdata"}, rsp_rdata, exp_rd);
        check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".hold_rdata"}, rsp_rdata, exp_rd);
            check({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
        check({tag, ".ready_again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic [2:0]  f3_tab [8];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.release_ready", 32'(req_ready), 32'd1);

        // rsp_ready outside RESP has no effect
        @(negedge clk); rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle.rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle.req_ready", 32'(req_ready), 32'd1);
        @(negedge clk); rsp_ready = 1'b0;

        // Preload the window of words used by everything below
        for (int w = 0; w < 16; w++) do_req(1'b1, 32'(w*4), $urandom, 3'd2, 0, "preload");

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, "t1.sw");
        do_req(1'b0, 32'h10, 32'h0, 3'd2, 0, "t1.lw");
        do_req(1'b1, 32'h13, 32'h80, 3'd0, 0, "t2.sb");
        do_req(1'b0, 32'h13, 32'h0, 3'd0, 0, "t2.lb");
        do_req(1'b0, 32'h13, 32'h0, 3'd4, 0, "t2.lbu");
        do_req(1'b0, 32'h10, 32'h0, 3'd2, 5, "t3.lw_hold");
        check("t2.model", {model_mem[19], model_mem[18], model_mem[17], model_mem[16]}, 32'h80ADBEEF);
        do_req(1'b1, 32'h1000, 32'h12345678, 3'd2, 0, "t4.sw_wrap");
        do_req(1'b0, 32'h0, 32'h0, 3'd2, 0, "t4.lw");
        do_req(1'b1, 32'h22, 32'h1, 3'd2, 0, "t5.sw_mis");
        do_req(1'b0, 32'h20, 32'h0, 3'd2, 0, "t5.lw");

        // Reset while the store is waiting: it must never commit
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hAAAA5555; req_funct3 = 3'd2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t6.rst_ready", 32'(req_ready), 32'd0);
        check("t6.rst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6.first_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, 32'h30, 32'h0, 3'd2, 0, "t6.lw");

        // Random traffic within the preloaded window, with address aliasing
        for (int k = 0; k < 60; k++) begin
            a  = 32'($urandom_range(0, 63)) + 32'($urandom_range(0, 3)) * c_BYTES;
            f3 = f3_tab[$urandom_range(0, 7)];
            do_req(1'($urandom_range(0, 1)), a, $urandom, f3, $urandom_range(0, 2), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
